// File: rtl/serial_alu_pkg.sv
// Shared encodings for the digit-serial ALU: opcodes, FSM states and an op-class helper.
package serial_alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_PASSA = 3'd5;
    localparam logic [2:0] OP_PASSB = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple adder; exposes the carry into the top bit so the caller can form signed overflow.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT - 1];

endmodule

// File: rtl/digit_serial_alu.sv
// Digit-serial ALU: LSB-first operands, DIGIT bits per clock, registered result digits and end-of-op flags.
module digit_serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    output logic             busy,
    output logic [DIGIT-1:0] rd_dig,
    output logic             dig_valid,
    output logic             done,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N      = WIDTH / DIGIT;
    localparam int BEAT_W = $clog2(N) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

    state_e             state_q;
    logic [2:0]         op_q;
    logic [BEAT_W-1:0]  beat_q;
    logic               carry_q;
    logic               zacc_q;
    logic [DIGIT-1:0]   rd_dig_q;
    logic               dig_valid_q;
    logic               done_q;
    logic               carry_out_q;
    logic               overflow_q;
    logic               zero_q;

    logic [DIGIT-1:0]   b_opnd;
    logic [DIGIT-1:0]   sum;
    logic               cout;
    logic               c_msb;
    logic [DIGIT-1:0]   result_d;
    logic               zacc_d;
    logic               arith;

    // Subtraction is a + ~b with the carry seeded to 1 at start.
    assign b_opnd = (op_q == OP_SUB) ? ~b_dig : b_dig;

    digit_adder #(.DIGIT(DIGIT)) u_adder (
        .a     (a_dig),
        .b     (b_opnd),
        .cin   (carry_q),
        .sum   (sum),
        .cout  (cout),
        .c_msb (c_msb)
    );

    always_comb begin
        result_d = a_dig;
        case (op_q)
            OP_ADD, OP_SUB: result_d = sum;
            OP_AND:         result_d = a_dig & b_dig;
            OP_OR:          result_d = a_dig | b_dig;
            OP_XOR:         result_d = a_dig ^ b_dig;
            OP_PASSB:       result_d = b_dig;
            default:        result_d = a_dig;
        endcase
    end

    assign arith  = is_arith(op_q);
    assign zacc_d = zacc_q & (result_d == '0);

    // NOTE: all state updates use <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            beat_q      <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            rd_dig_q    <= '0;
            dig_valid_q <= 1'b0;
            done_q      <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dig_valid_q <= 1'b0;
                    done_q      <= 1'b0;
                    if (start) begin
                        state_q <= ST_RUN;
                        op_q    <= op;
                        beat_q  <= '0;
                        zacc_q  <= 1'b1;
                        carry_q <= (op == OP_SUB);
                    end
                end
                ST_RUN: begin
                    rd_dig_q    <= result_d;
                    dig_valid_q <= 1'b1;
                    carry_q     <= cout;
                    zacc_q      <= zacc_d;
                    beat_q      <= beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        carry_out_q <= arith & cout;
                        overflow_q  <= arith & (c_msb ^ cout);
                        zero_q      <= zacc_d;
                    end
                end
                ST_DONE: begin
                    dig_valid_q <= 1'b0;
                    done_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign rd_dig    = rd_dig_q;
    assign dig_valid = dig_valid_q;
    assign done      = done_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule
